// File: rtl/image_pkg.sv
`default_nettype none
// ============================================================================
// Module   : image_pkg
// Brief    : Shared image geometry defaults, pixel/window types and the
//            Sobel stage state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package image_pkg;

    localparam int c_IMAGE_WIDTH  = 130;
    localparam int c_IMAGE_HEIGHT = 130;
    // One output pixel per interior input pixel (the border has no full window)
    localparam int c_OUT_PIXELS   = (c_IMAGE_WIDTH - 2) * (c_IMAGE_HEIGHT - 2);

    typedef logic [7:0] pixel_t;

    // Row-major 3x3 window: [0..2] top row, [3..5] middle row, [6..8] bottom row
    typedef pixel_t [8:0] window_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sobel_state_t;

endpackage : image_pkg
`default_nettype wire

// File: rtl/sobel_kernel.sv
`default_nettype none
// ============================================================================
// Module   : sobel_kernel
// Brief    : Combinational Sobel Gx/Gy operator over one 3x3 window.
//            Outputs are signed 11-bit, range -1020..+1020.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_kernel
    import image_pkg::*;
(
    input  window_t            i_window,
    output logic signed [10:0] o_gx,
    output logic signed [10:0] o_gy
);

    // Weighted column/row sums are non-negative and at most 1020, so an
    // 11-bit unsigned difference reinterpreted as signed is exact.
    logic [10:0] w_x_pos;
    logic [10:0] w_x_neg;
    logic [10:0] w_y_pos;
    logic [10:0] w_y_neg;

    assign w_x_pos = 11'(i_window[2]) + {2'b00, i_window[5], 1'b0} + 11'(i_window[8]);
    assign w_x_neg = 11'(i_window[0]) + {2'b00, i_window[3], 1'b0} + 11'(i_window[6]);
    assign w_y_pos = 11'(i_window[6]) + {2'b00, i_window[7], 1'b0} + 11'(i_window[8]);
    assign w_y_neg = 11'(i_window[0]) + {2'b00, i_window[1], 1'b0} + 11'(i_window[2]);

    assign o_gx = signed'(w_x_pos - w_x_neg);
    assign o_gy = signed'(w_y_pos - w_y_neg);

endmodule : sobel_kernel
`default_nettype wire

// File: rtl/sobel_edge_stage.sv
`default_nettype none
// ============================================================================
// Module   : sobel_edge_stage
// Brief    : 3-stage Sobel magnitude pipeline (|Gx|+|Gy|, saturate, optional
//            threshold) writing one result per window to the output BRAM at
//            a self-incrementing address; flags frame completion.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_edge_stage
    import image_pkg::*;
#(
    parameter int IMAGE_WIDTH  = c_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = c_IMAGE_HEIGHT,
    parameter int OUT_ADDR_W   = 14
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  window_valid,
    input  window_t               window,
    input  logic                  frame_start,
    input  logic                  threshold_en,
    input  logic [7:0]            threshold,
    output logic                  out_we,
    output logic [OUT_ADDR_W-1:0] out_addr,
    output logic [7:0]            out_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overflow
);

    localparam int                    c_N         = (IMAGE_WIDTH - 2) * (IMAGE_HEIGHT - 2);
    localparam logic [OUT_ADDR_W-1:0] c_LAST_ADDR = OUT_ADDR_W'(c_N - 1);

    sobel_state_t          r_state;
    sobel_state_t          w_next_state;

    logic                  r_v1, r_v2, r_v3;
    logic signed [10:0]    r_gx, r_gy;
    logic [10:0]           r_mag;
    logic [7:0]            r_out_data;
    logic [OUT_ADDR_W-1:0] r_addr;
    logic                  r_overflow;

    logic signed [10:0]    w_gx, w_gy;
    logic [10:0]           w_abs_gx, w_abs_gy;
    logic [7:0]            w_sat;
    logic [7:0]            w_out_pix;
    logic                  w_accept;
    logic                  w_final_write;

    // frame_start takes priority over a coincident window; DONE drops windows
    assign w_accept      = window_valid && !frame_start && (r_state != DONE);
    assign w_final_write = r_v3 && (r_addr == c_LAST_ADDR);

    sobel_kernel u_kernel (
        .i_window (window),
        .o_gx     (w_gx),
        .o_gy     (w_gy)
    );

    assign w_abs_gx  = r_gx[10] ? unsigned'(-r_gx) : unsigned'(r_gx);
    assign w_abs_gy  = r_gy[10] ? unsigned'(-r_gy) : unsigned'(r_gy);
    assign w_sat     = (r_mag > 11'd255) ? 8'hFF : r_mag[7:0];
    assign w_out_pix = threshold_en ? ((w_sat >= threshold) ? 8'hFF : 8'h00) : w_sat;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next_state = RUN;
            end
            RUN: begin
                if (frame_start)        w_next_state = IDLE;
                else if (w_final_write) w_next_state = DONE;
            end
            DONE: begin
                if (frame_start) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Status outputs derived from state and pipeline occupancy
    always_comb begin
        frame_done = (r_state == DONE);
        busy       = (r_state == RUN) || r_v1 || r_v2 || r_v3;
    end

    // Pipeline valid bits; frame_start flushes anything in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (frame_start) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            r_v1 <= w_accept;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    // Pipeline data: gradients, magnitude, final pixel (threshold sampled here)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gx       <= '0;
            r_gy       <= '0;
            r_mag      <= '0;
            r_out_data <= '0;
        end else begin
            if (w_accept) begin
                r_gx <= w_gx;
                r_gy <= w_gy;
            end
            if (r_v1) r_mag      <= w_abs_gx + w_abs_gy;
            if (r_v2) r_out_data <= w_out_pix;
        end
    end

    // Write address: advances per write, wraps after the last pixel of a frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr <= '0;
        end else if (frame_start) begin
            r_addr <= '0;
        end else if (r_v3) begin
            r_addr <= w_final_write ? '0 : r_addr + OUT_ADDR_W'(1);
        end
    end

    // Sticky overflow: a window arrived after the frame completed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (frame_start) begin
            r_overflow <= 1'b0;
        end else if (window_valid && (r_state == DONE)) begin
            r_overflow <= 1'b1;
        end
    end

    assign out_we   = r_v3;
    assign out_addr = r_addr;
    assign out_data = r_out_data;
    assign overflow = r_overflow;

endmodule : sobel_edge_stage
`default_nettype wire

// File: doc/sobel_edge_stage.md
Name: sobel_edge_stage

Overview:
- Consumes the 3x3 pixel windows produced by the BRAM window controller. A window is valid for one cycle when the controller's stall is low.
- Computes the Sobel gradient magnitude |Gx|+|Gy| in a 3-stage pipeline, saturates it to 8 bits and optionally thresholds it to binary.
- Writes one result per window into the output-image BRAM at a self-incrementing address.
- Flags frame completion after (IMAGE_WIDTH-2)*(IMAGE_HEIGHT-2) writes.

Parameters:
- IMAGE_WIDTH, 130, input image columns.
- IMAGE_HEIGHT, 130, input image rows.
- OUT_ADDR_W, 14, output BRAM address width; must satisfy 2^OUT_ADDR_W >= (IMAGE_WIDTH-2)*(IMAGE_HEIGHT-2).

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- window_valid  input  1  window present this cycle; driven from the controller's stall, inverted.
- window  input  8x9  pixels [8:0], row-major: 0-2 top row, 3-5 middle row, 6-8 bottom row; unsigned.
- frame_start  input  1  one-cycle pulse; re-arms the block for a new frame.
- threshold_en  input  1  selects binary output.
- threshold  input  8  binary cut level.
- out_we  output  1  output BRAM write enable.
- out_addr  output  OUT_ADDR_W  output BRAM write address.
- out_data  output  8  output pixel.
- busy  output  1  high in RUN or while the pipeline holds data.
- frame_done  output  1  level; high in DONE.
- overflow  output  1  sticky; set when a window arrives in DONE.

Behaviour:
- Reset (async, reset=0):
  - Pipeline valid bits clear immediately, so out_we goes low combinationally-from-flops at once.
  - out_addr=0, out_data=0, busy=0, frame_done=0, overflow=0, state=IDLE.
  - A reset mid-frame discards all in-flight windows.
- States and transitions:
  - IDLE -> RUN on the first accepted window.
  - RUN -> DONE on the cycle the final write (address N-1, where N=(W-2)*(H-2)) is issued.
  - DONE -> IDLE on frame_start.
  - frame_start in IDLE or RUN: out_addr:=0, pixel count:=0, overflow:=0, state:=IDLE. In-flight pipeline data is flushed without being written.
- Acceptance:
  - In IDLE and RUN, every cycle with window_valid=1 is accepted. Back-to-back valid on every cycle is supported; there is no backpressure.
  - In DONE, windows are dropped and overflow:=1.
  - frame_start and window_valid in the same cycle: frame_start wins and the window is dropped.
- Stage 1 (registered, signed 11-bit):
  - Gx = (p2 + 2*p5 + p8) - (p0 + 2*p3 + p6)
  - Gy = (p6 + 2*p7 + p8) - (p0 + 2*p1 + p2)
  - Range of each is -1020..+1020.
- Stage 2 (registered, unsigned 11-bit): mag = |Gx| + |Gy|, range 0..2040.
- Stage 3 (registered output):
  - sat = (mag > 255) ? 255 : mag[7:0].
  - threshold_en=1: out_data = (sat >= threshold) ? 255 : 0. Otherwise out_data = sat.
  - threshold_en and threshold are sampled in stage 3.
- Latency: window accepted at cycle T -> out_we=1 with valid out_addr/out_data at cycle T+3. out_we is high for one cycle per window.
- Addressing:
  - out_addr holds the address of the current write.
  - It increments after each write and wraps to 0 after N-1, on the same edge that enters DONE.
  - frame_done rises in the cycle after the final write.
- busy = (state==RUN) OR any pipeline valid bit set.

Decomposition:
- Shared package image_pkg holds:
  - IMAGE_WIDTH/IMAGE_HEIGHT defaults.
  - OUT_PIXELS constant.
  - typedef pixel_t (8-bit).
  - typedef window_t (array of 9 pixel_t).
  - enum sobel_state_t {IDLE, RUN, DONE}.
- One sub-module, sobel_kernel: the combinational Gx/Gy computation from a window_t, instantiated ahead of the stage-1 register.
- Pipeline registers, FSM and address counter live in sobel_edge_stage.

Test Plan:
- Flat window: all pixels 100, threshold_en=0 -> out_data=0 three cycles after valid, out_addr=0, out_we one cycle.
- Vertical edge: p0,p3,p6=0; p2,p5,p8=255; middle column 128 -> Gx=1020, Gy=0, out_data=255 (saturated).
- Small gradient: p2=p5=p8=10, rest 0 -> Gx=40, Gy=0, out_data=40. Repeat with threshold_en=1, threshold=50 -> 0; with threshold=30 -> 255.
- Full frame: 16384 windows, valid on every cycle:
  - Addresses run 0..16383 contiguous.
  - frame_done=1 the cycle after write 16383; out_addr back to 0.
  - A further window sets overflow=1 with no write.
  - frame_start then clears overflow and frame_done and returns the block to IDLE.
- Sparse valid: valid every 9th cycle (controller cadence) -> one write per window at T+3; addresses consecutive.
- Async reset: reset low while two windows are in flight -> out_we=0 immediately, no writes; after release the next window writes to address 0.
